// File: rtl/tx_resp_sched.sv
// Response scheduler: shares one TX FIFO write port between a one-byte register read
// response and a two-byte ALU response (LS byte first), with round-robin arbitration.
//
// state       | meaning
// ------------+-----------------------------------------------------
// IDLE        | nothing being sent; arbitrate between pending slots
// SEND_RD     | presenting the register read byte
// SEND_ALU_LO | presenting the ALU low byte
// SEND_ALU_HI | presenting the ALU high byte
module tx_resp_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16   // must be 2*DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_vld,
    input  logic [ALU_WIDTH-1:0]  alu_out,
    input  logic                  alu_vld,
    input  logic                  fifo_full,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_wr_en,
    output logic                  busy,
    output logic                  ovf_err
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_RD     = 2'd1,
        SEND_ALU_LO = 2'd2,
        SEND_ALU_HI = 2'd3
    } state_t;

    localparam logic GRANT_RD  = 1'b0;
    localparam logic GRANT_ALU = 1'b1;

    state_t                state;
    state_t                state_nxt;
    logic                  last_grant;
    logic                  last_grant_nxt;
    logic [DATA_WIDTH-1:0] rd_slot;
    logic                  rd_pend;
    logic [ALU_WIDTH-1:0]  alu_slot;
    logic                  alu_pend;
    logic                  rd_free;
    logic                  alu_free;
    logic                  rd_drop;
    logic                  alu_drop;

    assign fifo_wr_en = (state != IDLE) && !fifo_full;
    assign busy       = (state != IDLE) || rd_pend || alu_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_ALU;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // last_grant only moves on contested grants, so an uncontested grant does not
    // cost the other source its turn.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        rd_free        = 1'b0;
        alu_free       = 1'b0;
        fifo_wr_data   = '0;
        case (state)
            IDLE: begin
                if (rd_pend && alu_pend) begin
                    if (last_grant == GRANT_ALU) begin
                        state_nxt      = SEND_RD;
                        last_grant_nxt = GRANT_RD;
                    end else begin
                        state_nxt      = SEND_ALU_LO;
                        last_grant_nxt = GRANT_ALU;
                    end
                end else if (rd_pend) begin
                    state_nxt = SEND_RD;
                end else if (alu_pend) begin
                    state_nxt = SEND_ALU_LO;
                end
            end
            SEND_RD: begin
                fifo_wr_data = rd_slot;
                if (!fifo_full) begin
                    state_nxt = IDLE;
                    rd_free   = 1'b1;
                end
            end
            SEND_ALU_LO: begin
                fifo_wr_data = alu_slot[DATA_WIDTH-1:0];
                if (!fifo_full) begin
                    state_nxt = SEND_ALU_HI;
                end
            end
            SEND_ALU_HI: begin
                fifo_wr_data = alu_slot[ALU_WIDTH-1:DATA_WIDTH];
                if (!fifo_full) begin
                    state_nxt = IDLE;
                    alu_free  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A slot may be reloaded on the very edge its last byte is written.
    assign rd_drop  = rd_vld  && rd_pend  && !rd_free;
    assign alu_drop = alu_vld && alu_pend && !alu_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_slot  <= '0;
            rd_pend  <= 1'b0;
            alu_slot <= '0;
            alu_pend <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            if (rd_vld && !rd_drop) begin
                rd_slot <= rd_data;
                rd_pend <= 1'b1;
            end else if (rd_free) begin
                rd_pend <= 1'b0;
            end

            if (alu_vld && !alu_drop) begin
                alu_slot <= alu_out;
                alu_pend <= 1'b1;
            end else if (alu_free) begin
                alu_pend <= 1'b0;
            end

            if (rd_drop || alu_drop) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
        end
    end

endmodule
